// File: rtl/hub75_scan_driver.sv
// HUB75 scan driver: reads row pairs from the framebuffer read port and drives the
// panel with binary-coded modulation (one shift + latch + weighted display per bit plane).
module hub75_scan_driver #(
    parameter int WIDTH       = 96,
    parameter int HEIGHT      = 48,
    parameter int BPC         = 4,
    parameter int CHAINED     = 1,
    parameter int BASE_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [11:0] mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_data,
    output logic        r0,
    output logic        g0,
    output logic        b0,
    output logic        r1,
    output logic        g1,
    output logic        b1,
    output logic        sclk,
    output logic        lat,
    output logic        oe_n,
    output logic [4:0]  row_addr,
    output logic        frame_done
);

    localparam int N    = CHAINED * WIDTH;
    localparam int ROWS = HEIGHT / 2;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW   = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int DW   = $clog2((BASE_CYCLES << (BPC - 1)) + 1);

    typedef enum logic [2:0] {IDLE, PREFETCH, SHIFT_LO, SHIFT_HI, LATCH, DISPLAY, NEXT} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   col, col_nxt;
    logic [RW-1:0]   row, row_nxt;
    logic [PW-1:0]   plane, plane_nxt;
    logic [11:0]     base, base_nxt;
    logic [DW-1:0]   dcnt, dcnt_nxt;
    logic [11:0]     addr_nxt;
    logic            re_nxt, sclk_nxt, lat_nxt, oe_n_nxt, done_nxt;
    logic [5:0]      rgb, rgb_nxt;
    logic [4:0]      row_addr_nxt;

    logic [3:0] nr0, ng0, nb0, nr1, ng1, nb1;
    logic       unused_hi;

    assign nr0 = mem_data[23:20];
    assign ng0 = mem_data[19:16];
    assign nb0 = mem_data[15:12];
    assign nr1 = mem_data[11:8];
    assign ng1 = mem_data[7:4];
    assign nb1 = mem_data[3:0];
    assign unused_hi = ^mem_data[31:24];

    assign {r0, g0, b0, r1, g1, b1} = rgb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            plane      <= '0;
            base       <= '0;
            dcnt       <= '0;
            mem_addr   <= '0;
            mem_re     <= 1'b0;
            rgb        <= '0;
            sclk       <= 1'b0;
            lat        <= 1'b0;
            oe_n       <= 1'b1;
            row_addr   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            col        <= col_nxt;
            row        <= row_nxt;
            plane      <= plane_nxt;
            base       <= base_nxt;
            dcnt       <= dcnt_nxt;
            mem_addr   <= addr_nxt;
            mem_re     <= re_nxt;
            rgb        <= rgb_nxt;
            sclk       <= sclk_nxt;
            lat        <= lat_nxt;
            oe_n       <= oe_n_nxt;
            row_addr   <= row_addr_nxt;
            frame_done <= done_nxt;
        end
    end

    // Outputs are registered, so each branch sets the pins for the state being entered.
    always_comb begin
        state_nxt    = state;
        col_nxt      = col;
        row_nxt      = row;
        plane_nxt    = plane;
        base_nxt     = base;
        dcnt_nxt     = dcnt;
        addr_nxt     = mem_addr;
        re_nxt       = 1'b0;
        rgb_nxt      = rgb;
        sclk_nxt     = 1'b0;
        lat_nxt      = 1'b0;
        oe_n_nxt     = 1'b1;
        row_addr_nxt = row_addr;
        done_nxt     = 1'b0;
        case (state)
            IDLE: begin
                rgb_nxt      = '0;
                addr_nxt     = '0;
                row_addr_nxt = '0;
                if (en) begin
                    state_nxt = PREFETCH;
                    col_nxt   = '0;
                    row_nxt   = '0;
                    plane_nxt = '0;
                    base_nxt  = '0;
                    re_nxt    = 1'b1;
                end
            end
            PREFETCH: state_nxt = SHIFT_LO;
            SHIFT_LO: begin
                state_nxt = SHIFT_HI;
                sclk_nxt  = 1'b1;
                rgb_nxt   = {nr0[plane], ng0[plane], nb0[plane], nr1[plane], ng1[plane], nb1[plane]};
                if (col < CW'(N - 1)) begin
                    re_nxt   = 1'b1;
                    addr_nxt = mem_addr + 12'd1;
                end
            end
            SHIFT_HI: begin
                if (col < CW'(N - 1)) begin
                    state_nxt = SHIFT_LO;
                    col_nxt   = col + 1'b1;
                end else begin
                    state_nxt    = LATCH;
                    lat_nxt      = 1'b1;
                    row_addr_nxt = 5'(row);
                end
            end
            LATCH: begin
                state_nxt = DISPLAY;
                oe_n_nxt  = 1'b0;
                dcnt_nxt  = DW'((BASE_CYCLES << plane) - 1);
            end
            DISPLAY: begin
                if (dcnt == '0) begin
                    state_nxt = NEXT;
                    done_nxt  = (row == RW'(ROWS - 1)) && (plane == PW'(BPC - 1));
                end else begin
                    dcnt_nxt = dcnt - 1'b1;
                    oe_n_nxt = 1'b0;
                end
            end
            NEXT: begin
                col_nxt = '0;
                if (plane < PW'(BPC - 1)) begin
                    plane_nxt = plane + 1'b1;
                end else begin
                    plane_nxt = '0;
                    if (row == RW'(ROWS - 1)) begin
                        row_nxt  = '0;
                        base_nxt = '0;
                    end else begin
                        row_nxt  = row + 1'b1;
                        base_nxt = base + 12'(N);
                    end
                end
                // frame_done is high in this cycle exactly when the frame is wrapping
                if (frame_done && !en) begin
                    state_nxt    = IDLE;
                    rgb_nxt      = '0;
                    addr_nxt     = '0;
                    row_addr_nxt = '0;
                end else begin
                    state_nxt = PREFETCH;
                    re_nxt    = 1'b1;
                    addr_nxt  = base_nxt;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
